// File: rtl/rr_enc_pkg.sv
// Shared types and helpers for the round-robin code encoder.
// The one-hot bit mapping here matches the 2-to-4 decoder: code c drives bit INWID-1-c.
package rr_enc_pkg;

  localparam int CODEWID = 2;
  localparam int INWID   = 2 ** CODEWID;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } enc_state_t;

  function automatic logic [INWID-1:0] code2onehot(input logic [CODEWID-1:0] c);
    logic [INWID-1:0] onehot;
    onehot = '0;
    onehot[INWID-1-int'(c)] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requesting code after `last`, with wrap.
// Requests are rotated into search order, the lowest set bit is found, and the offset is rotated back.
module rr_pick
  import rr_enc_pkg::*;
#(
  parameter int CODEWID = 2,
  parameter int INWID   = 4
) (
  input  logic [INWID-1:0]   req,
  input  logic [CODEWID-1:0] last,
  output logic [CODEWID-1:0] pick,
  output logic               any
);

  logic [INWID-1:0]   by_code;
  logic [INWID-1:0]   rot;
  logic [CODEWID-1:0] offset;

  // rot[i] is the request for code last+1+i; CODEWID-bit addition gives the wrap for free
  generate
    for (genvar gi = 0; gi < INWID; gi++) begin : g_rot
      logic [CODEWID-1:0] src;
      assign by_code[gi] = req[INWID-1-gi];
      assign src         = last + CODEWID'(gi + 1);
      assign rot[gi]     = by_code[src];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = INWID - 1; i >= 0; i--) begin
      if (rot[i]) offset = CODEWID'(i);
    end
    pick = last + CODEWID'(1) + offset;
    any  = |req;
  end

endmodule

// File: rtl/rr_code_encoder.sv
// Round-robin request encoder with valid/ack handshake; inverse of the 2-to-4 one-hot decoder.
// Holds code/grant until acked, and re-arbitrates on the acking edge so streams have no bubble.
module rr_code_encoder
  import rr_enc_pkg::*;
#(
  parameter int CODEWID = 2,
  parameter int INWID   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               En,
  input  logic [INWID-1:0]   req,
  input  logic               ack,
  output logic [CODEWID-1:0] code,
  output logic               valid,
  output logic [INWID-1:0]   grant
);

  enc_state_t         state_reg, state_next;
  logic [CODEWID-1:0] code_reg, code_next;
  logic [INWID-1:0]   grant_reg, grant_next;
  logic [CODEWID-1:0] last_reg, last_next;
  logic [CODEWID-1:0] search_last;
  logic [CODEWID-1:0] pick;
  logic               any;

  // An ack in HOLD retires the current code, so the same-edge search must start after it
  assign search_last = (state_reg == HOLD && ack) ? code_reg : last_reg;

  rr_pick #(
    .CODEWID(CODEWID),
    .INWID  (INWID)
  ) u_pick (
    .req (req),
    .last(search_last),
    .pick(pick),
    .any (any)
  );

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (En && any) begin
          state_next = HOLD;
          code_next  = pick;
          grant_next = code2onehot(pick);
        end
      end
      HOLD: begin
        if (ack) begin
          last_next = code_reg;
          if (En && any) begin
            code_next  = pick;
            grant_next = code2onehot(pick);
          end else begin
            state_next = IDLE;
            code_next  = '0;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        code_next  = '0;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      code_reg  <= '0;
      grant_reg <= '0;
      last_reg  <= CODEWID'(INWID - 1);
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
    end
  end

  assign code  = code_reg;
  assign grant = grant_reg;
  assign valid = (state_reg == HOLD);

endmodule

// File: tb/tb_rr_code_encoder.sv
// Scenario bench for rr_code_encoder: each step pushes its expected outputs to a scoreboard
// queue, clocks one edge, then pops and compares against the registered outputs.
module tb_rr_code_encoder;

  logic       clk;
  logic       rst_n;
  logic       En;
  logic [3:0] req;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic [3:0] grant;

  int checks   = 0;
  int failures = 0;

  // rn, en, rq, ak = stimulus for the edge; v, c, g = outputs expected after it
  typedef struct packed {
    logic       rn;
    logic       en;
    logic [3:0] rq;
    logic       ak;
    logic       v;
    logic [1:0] c;
    logic [3:0] g;
  } step_t;

  typedef struct packed {
    logic       v;
    logic [1:0] c;
    logic [3:0] g;
  } exp_t;

  exp_t sb[$];

  rr_code_encoder #(
    .CODEWID(2),
    .INWID  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .En   (En),
    .req  (req),
    .ack  (ack),
    .code (code),
    .valid(valid),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    step_t t[2];
    exp_t  e;
    t = '{'{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000},
          '{1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'b00, 4'b0000}};
    for (int i = 0; i < 2; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL reset step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("reset step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  task automatic test_hold();
    step_t t[5];
    exp_t  e;
    t = '{'{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1, 2'b01, 4'b0100},
          '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'b01, 4'b0100},
          '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'b01, 4'b0100},
          '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 2'b01, 4'b0100},
          '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000}};
    for (int i = 0; i < 5; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL hold step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("hold step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  // Entered with last=01: code 11 must win over code 00, then 00 follows
  task automatic test_rotation();
    step_t t[3];
    exp_t  e;
    t = '{'{1'b1, 1'b1, 4'b1001, 1'b0, 1'b1, 2'b11, 4'b0001},
          '{1'b1, 1'b1, 4'b1001, 1'b1, 1'b1, 2'b00, 4'b1000},
          '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000}};
    for (int i = 0; i < 3; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL rotation step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("rotation step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  task automatic test_back_to_back();
    step_t t[7];
    exp_t  e;
    t = '{'{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 2'b00, 4'b1000},
          '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'b01, 4'b0100},
          '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'b10, 4'b0010},
          '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'b11, 4'b0001},
          '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 2'b00, 4'b1000},
          '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000}};
    for (int i = 0; i < 7; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL back_to_back step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("back_to_back step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  task automatic test_enable();
    step_t t[5];
    exp_t  e;
    t = '{'{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 2'b00, 4'b1000}};
    for (int i = 0; i < 5; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL enable step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("enable step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  // Entered in HOLD with code 00 and last=11
  task automatic test_reset_mid_hold();
    step_t t[3];
    exp_t  e;
    t = '{'{1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'b10, 4'b0010},
          '{1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 2'b00, 4'b1000}};
    for (int i = 0; i < 3; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL reset_mid_hold step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("reset_mid_hold step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  // req=1010 after idle acks picks 00 only if last stayed at 11
  task automatic test_idle_ack();
    step_t t[6];
    exp_t  e;
    t = '{'{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000},
          '{1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 2'b00, 4'b1000},
          '{1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'b10, 4'b0010},
          '{1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000}};
    for (int i = 0; i < 6; i++) begin
      rst_n = t[i].rn; En = t[i].en; req = t[i].rq; ack = t[i].ak;
      sb.push_back('{t[i].v, t[i].c, t[i].g});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({valid, code, grant} !== {e.v, e.c, e.g}) begin
        failures++;
        $display("FAIL idle_ack step %0d: got valid=%b code=%b grant=%b, expected valid=%b code=%b grant=%b",
                 i, valid, code, grant, e.v, e.c, e.g);
      end
      $display("idle_ack step %0d: valid=%b code=%b grant=%b", i, valid, code, grant);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    En    = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_hold();
    test_rotation();
    test_back_to_back();
    test_enable();
    test_reset_mid_hold();
    test_idle_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_code_encoder.md
# rr_code_encoder

Round-robin request encoder: the inverse of the team's 2-to-4 one-hot decoder. It accepts up to four one-hot request lines, selects one with rotating priority, and presents its 2-bit code with a valid/ack handshake. It sits in cpu001 between the requesting units and the code-consuming control path. Its `grant` output and the decoder's output agree bit for bit for the same code.

## Interface
- `CODEWID`, default 2: code width.
- `INWID`, default 4: request/grant width. Must equal 2**CODEWID.
- `clk`, input, 1: the single clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `En`, input, 1: arbitration enable.
- `req`, input, INWID: request lines. Code c maps to `req[INWID-1-c]`, so `req[3]` maps to code 00 and `req[0]` to code 11.
- `ack`, input, 1: the consumer has taken the current code.
- `code`, output, CODEWID: selected code.
- `valid`, output, 1: `code`/`grant` hold a transaction.
- `grant`, output, INWID: one-hot form of `code`, using the same bit mapping; all zeros when `valid`=0.

## Operation
- States:
  - IDLE: `valid`=0.
  - HOLD: `valid`=1.
- Pointer `last` (CODEWID bits) holds the most recently acked code. Reset value is INWID-1, so the first search starts at code 0.
- Selection (combinational):
  - Search codes `last+1`, `last+2`, … `last+INWID`, all modulo INWID (wrap-around).
  - Pick the first code c with `req[INWID-1-c]`=1.
  - `any` = |`req`.
- IDLE to HOLD: at an edge with `En`=1 and `any`=1, register the picked `code`, `grant`=1<<(INWID-1-c), and `valid`=1.
- IDLE, otherwise: stay in IDLE; outputs remain zero.
- HOLD, `ack`=0: `code`, `grant` and `valid` are held, regardless of `req` or `En` changes. A withdrawn request does not cancel a transaction.
- HOLD, `ack`=1:
  - `last` takes the current `code`.
  - If `En`=1 and `any`=1, re-arbitrate in the same edge using the updated `last`, and stay in HOLD with the new code (back-to-back, no bubble).
  - Otherwise go to IDLE: `valid`, `code` and `grant` are all 0.
- `ack` while in IDLE is ignored.
- `En` is sampled only when a new selection is made.
- Reset (`rst_n`=0 at an edge, including mid-HOLD):
  - state IDLE, `valid`=0, `code`=0, `grant`=0, `last`=INWID-1.
  - Any pending transaction is dropped.

## Timing
- Reset values: `valid`=0, `code`=0, `grant`=0.
- All outputs are registered; there is no combinational path from input to output.
- Latency:
  - A request sampled at edge k is visible on `code`/`valid` after edge k.
  - `ack` sampled at edge k changes outputs after edge k.
- Throughput: one transaction per cycle when `ack` is held high with continuous requests.
- Fairness: with all four lines requesting continuously, the grant order is codes 0, 1, 2, 3, 0, …
- A requester waits at most INWID-1 other transactions.
- When `req` and `ack` change at the same edge, the new selection uses `req` as sampled at that edge.

## Structure
- Shared package `rr_enc_pkg`:
  - `CODEWID`, `INWID`.
  - State typedef {IDLE, HOLD}.
  - Function `code2onehot(c)`, returning 1<<(INWID-1-c).
- Sub-module `rr_pick`:
  - Combinational.
  - Inputs: `req`, `last`. Outputs: `pick` code, `any`.
  - Implementation: rotate `req` by `last`, find-first, rotate back.
- Top level holds the FSM, the `last` register and the output registers.

## Test plan
- Reset, then `req`=0100, `En`=1 → after 1 edge: `code`=01, `grant`=0100, `valid`=1. Hold `ack`=0 for 3 cycles → outputs unchanged, even if `req` is dropped.
- `req`=1111, `En`=1, `ack`=1 continuous → `code` sequence 00, 01, 10, 11, 00 on consecutive cycles, `valid` never drops.
- `last`=01 (code 01 acked), then `req`=1001 → `code`=11 (`grant`=0001) before code 00. Ack it → next `code`=00.
- `En`=0 with `req`=1111 → `valid` stays 0. Raise `En` → `code`=00 on the next edge.
- Mid-HOLD (`code`=10, `valid`=1), assert `rst_n`=0 for one edge → `valid`=0, `code`=00, `grant`=0000. Then `req`=1111 → `code`=00.
- `ack`=1 while IDLE with `req`=0 → no output change and `last` unchanged. A following `req`=0010 → `code`=10.
